// File: rtl/bus_master_arbiter.sv
// Round-robin arbiter sharing one bus_cdc port among NumMasters requesters,
// running one issue/wait/respond transaction at a time.
// Ports: clk_i, reset_n_i (async, active low); per-master req_i, we_i,
// we_ram_i, address_i, wdata_i, ack_o; shared rdata_o, grant_o, err_o;
// downstream bus_we_o, bus_we_ram_o, bus_address_o, bus_data_o,
// bus_data_i, bus_busy_i.
// Optional macro BUS_ARB_TIMEOUT_EN: bounds WAIT at TimeoutCycles and
// flags the forced completion on err_o.
module bus_master_arbiter #(
    parameter int NumMasters = 2,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter logic [AddrWidth-1:0] IdleAddress = '1,
    parameter int BusyWindow = 2,
    parameter int TimeoutCycles = 1024
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic [NumMasters-1:0]           req_i,
    input  logic [NumMasters-1:0]           we_i,
    input  logic [NumMasters*4-1:0]         we_ram_i,
    input  logic [NumMasters*AddrWidth-1:0] address_i,
    input  logic [NumMasters*DataWidth-1:0] wdata_i,
    output logic [NumMasters-1:0]           ack_o,
    output logic [DataWidth-1:0]            rdata_o,
    output logic [NumMasters-1:0]           grant_o,
    output logic                            err_o,
    output logic                            bus_we_o,
    output logic [3:0]                      bus_we_ram_o,
    output logic [AddrWidth-1:0]            bus_address_o,
    output logic [DataWidth-1:0]            bus_data_o,
    input  logic [DataWidth-1:0]            bus_data_i,
    input  logic                            bus_busy_i
);

    localparam int IdxW = (NumMasters > 1) ? $clog2(NumMasters) : 1;
    localparam int CntW = $clog2(TimeoutCycles + BusyWindow + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_GAP
    } state_t;

    state_t                state_q, state_d;
    logic [IdxW-1:0]       gnt_q, gnt_d;
    logic [IdxW-1:0]       ptr_q, ptr_d;
    logic                  we_q, we_d;
    logic [3:0]            we_ram_q, we_ram_d;
    logic [AddrWidth-1:0]  addr_q, addr_d;
    logic [DataWidth-1:0]  wdata_q, wdata_d;
    logic [DataWidth-1:0]  rdata_q, rdata_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  seen_q, seen_d;

    logic [3:0]            wr_arr [NumMasters];
    logic [AddrWidth-1:0]  ad_arr [NumMasters];
    logic [DataWidth-1:0]  wd_arr [NumMasters];

    logic                  found;
    logic [IdxW-1:0]       sel;
    logic                  drive;
    logic [NumMasters-1:0] gnt_oh;

    for (genvar m = 0; m < NumMasters; m++) begin : g_unpack
        assign wr_arr[m] = we_ram_i[4*m +: 4];
        assign ad_arr[m] = address_i[AddrWidth*m +: AddrWidth];
        assign wd_arr[m] = wdata_i[DataWidth*m +: DataWidth];
    end

    // Scan from the highest offset down so the requester closest at or
    // after ptr_q overrides any later one.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = NumMasters - 1; i >= 0; i--) begin
            int j;
            j = int'(ptr_q) + i;
            if (j >= NumMasters) j = j - NumMasters;
            if (req_i[IdxW'(j)]) begin
                found = 1'b1;
                sel   = IdxW'(j);
            end
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    logic err_q, err_d;
`endif

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        we_d     = we_q;
        we_ram_d = we_ram_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;
        seen_d   = seen_q;
`ifdef BUS_ARB_TIMEOUT_EN
        err_d    = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    gnt_d    = sel;
                    we_d     = we_i[sel];
                    we_ram_d = wr_arr[sel];
                    addr_d   = ad_arr[sel];
                    wdata_d  = wd_arr[sel];
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                seen_d  = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
                err_d   = 1'b0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CntW'(1);
                if (bus_busy_i) seen_d = 1'b1;
                // A slave that never raises busy inside the window is
                // zero-wait: its data is already valid.
                if (!bus_busy_i && (seen_q ||
                    cnt_q == CntW'(BusyWindow - 1))) begin
                    rdata_d = bus_data_i;
                    state_d = S_RESP;
                end
`ifdef BUS_ARB_TIMEOUT_EN
                else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
`endif
            end
            S_RESP: begin
                ptr_d   = (gnt_q == IdxW'(NumMasters - 1)) ?
                          '0 : gnt_q + IdxW'(1);
                state_d = S_GAP;
            end
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= S_IDLE;
            gnt_q    <= '0;
            ptr_q    <= '0;
            we_q     <= 1'b0;
            we_ram_q <= '0;
            addr_q   <= IdleAddress;
            wdata_q  <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
            seen_q   <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ptr_q    <= ptr_d;
            we_q     <= we_d;
            we_ram_q <= we_ram_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
            seen_q   <= seen_d;
`ifdef BUS_ARB_TIMEOUT_EN
            err_q    <= err_d;
`endif
        end
    end

    assign drive  = (state_q == S_ISSUE) || (state_q == S_WAIT) ||
                    (state_q == S_RESP);
    assign gnt_oh = NumMasters'(1) << gnt_q;

    assign grant_o       = drive ? gnt_oh : '0;
    assign ack_o         = (state_q == S_RESP) ? gnt_oh : '0;
    assign rdata_o       = rdata_q;
    assign bus_address_o = drive ? addr_q : IdleAddress;
    assign bus_data_o    = drive ? wdata_q : '0;
    assign bus_we_o      = (state_q == S_ISSUE) && we_q;
    assign bus_we_ram_o  = (state_q == S_ISSUE) ? we_ram_q : 4'b0;

`ifdef BUS_ARB_TIMEOUT_EN
    assign err_o = (state_q == S_RESP) && err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Scoreboard bench for bus_master_arbiter with a reactive bus_cdc slave
// model driving per-transaction busy profiles.
module tb_bus_master_arbiter;

    localparam int N  = 2;
    localparam int BW = 2;
    localparam int TO = 16;
    localparam logic [31:0] IDLE = 32'hFFFF_FFFF;
    localparam logic [31:0] BAD  = 32'hBAD0_BAD0;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  req_i, we_i, ack_o, grant_o;
    logic [N*4-1:0]  we_ram_i;
    logic [N*32-1:0] address_i, wdata_i;
    logic [31:0]   rdata_o, bus_address_o, bus_data_o, bus_data_i;
    logic          err_o, bus_we_o, bus_busy_i;
    logic [3:0]    bus_we_ram_o;

    bus_master_arbiter #(
        .NumMasters(N), .AddrWidth(32), .DataWidth(32),
        .IdleAddress(IDLE), .BusyWindow(BW), .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .req_i(req_i), .we_i(we_i), .we_ram_i(we_ram_i),
        .address_i(address_i), .wdata_i(wdata_i),
        .ack_o(ack_o), .rdata_o(rdata_o), .grant_o(grant_o),
        .err_o(err_o), .bus_we_o(bus_we_o),
        .bus_we_ram_o(bus_we_ram_o), .bus_address_o(bus_address_o),
        .bus_data_o(bus_data_o), .bus_data_i(bus_data_i),
        .bus_busy_i(bus_busy_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          m;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wr;
        logic [31:0] wd;
        int          d;
        int          len;
        logic [31:0] rd;
        logic        err;
        int          lat;
    } txn_t;

    txn_t txn_q[$];
    txn_t mon_t;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   ack_cnt = 0;
    int   issue_cnt = 0;
    int   issue_cyc = 0;
    logic slv_active = 1'b0;
    logic ack_prev = 1'b0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_m(int m, logic we, logic [3:0] wr,
                         logic [31:0] a, logic [31:0] wd);
        we_i[m]           = we;
        we_ram_i[4*m +: 4] = wr;
        address_i[32*m +: 32] = a;
        wdata_i[32*m +: 32]   = wd;
    endtask

    task automatic push(int m, logic [31:0] a, logic we, logic [3:0] wr,
                        logic [31:0] wd, int d, int len,
                        logic [31:0] rd, logic err, int lat);
        txn_t t;
        t.m = m; t.addr = a; t.we = we; t.wr = wr; t.wd = wd;
        t.d = d; t.len = len; t.rd = rd; t.err = err; t.lat = lat;
        txn_q.push_back(t);
    endtask

    task automatic wait_acks(int target, int limit);
        int n = 0;
        while (ack_cnt < target && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_ack", 64'(ack_cnt), 64'(target));
    endtask

    task automatic wait_slave_idle(int limit);
        int n = 0;
        while (slv_active && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check("slave_idle", 64'(slv_active), 64'(0));
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Slave: an idle->driven address edge marks the ISSUE cycle.
    initial begin
        logic [31:0] prev;
        txn_t t;
        prev = IDLE;
        bus_busy_i = 1'b0;
        bus_data_i = '0;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && prev == IDLE &&
                bus_address_o != IDLE) begin
                if (txn_q.size() == 0) begin
                    check("slv_unexp", 64'(bus_address_o), 64'(IDLE));
                end else begin
                    t = txn_q[0];
                    slv_active = 1'b1;
                    issue_cnt++;
                    issue_cyc = cyc;
                    check("iss_addr", 64'(bus_address_o), 64'(t.addr));
                    check("iss_gnt", 64'(grant_o), 64'(1 << t.m));
                    check("iss_we", 64'(bus_we_o), 64'(t.we));
                    check("iss_wr", 64'(bus_we_ram_o), 64'(t.wr));
                    check("iss_wd", 64'(bus_data_o), 64'(t.wd));
                    bus_data_i = (t.len == 0) ? t.rd : BAD;
                    @(negedge clk);
                    check("we_1cyc", 64'(bus_we_o), 64'(0));
                    if (t.len > 0) begin
                        repeat (t.d - 1) @(negedge clk);
                        bus_busy_i = 1'b1;
                        repeat (t.len) @(negedge clk);
                        bus_busy_i = 1'b0;
                        bus_data_i = t.rd;
                    end
                    slv_active = 1'b0;
                end
            end
            prev = bus_address_o;
        end
    end

    always @(negedge clk) begin
        if (ack_prev) check("ack_1cyc", 64'(ack_o), 64'(0));
        ack_prev = (ack_o != '0);
        if (ack_o != '0) begin
            if (txn_q.size() == 0) begin
                check("ack_unexp", 64'(ack_o), 64'(0));
            end else begin
                mon_t = txn_q.pop_front();
                check("ack_m", 64'(ack_o), 64'(1 << mon_t.m));
                check("rdata", 64'(rdata_o), 64'(mon_t.rd));
                check("err", 64'(err_o), 64'(mon_t.err));
                check("lat", 64'(cyc - issue_cyc), 64'(mon_t.lat));
                ack_cnt++;
            end
        end
    end

    task automatic check_idle(string tag);
        check({tag, "_ack"}, 64'(ack_o), 64'(0));
        check({tag, "_gnt"}, 64'(grant_o), 64'(0));
        check({tag, "_addr"}, 64'(bus_address_o), 64'(IDLE));
        check({tag, "_we"}, 64'(bus_we_o), 64'(0));
        check({tag, "_wr"}, 64'(bus_we_ram_o), 64'(0));
        check({tag, "_bd"}, 64'(bus_data_o), 64'(0));
        check({tag, "_rd"}, 64'(rdata_o), 64'(0));
        check({tag, "_err"}, 64'(err_o), 64'(0));
    endtask

    initial begin
        int base;
        int n;
        reset_n = 1'b0;
        req_i = '0; we_i = '0; we_ram_i = '0;
        address_i = '0; wdata_i = '0;
        repeat (3) @(negedge clk);
        check_idle("rst");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("post_rst");

        // busy read, master 0
        set_m(0, 1'b0, 4'h0, 32'h9000, 32'h0);
        push(0, 32'h9000, 1'b0, 4'h0, 32'h0, 2, 8,
             32'hDEAD_BEEF, 1'b0, 11);
        req_i = 2'b01;
        wait_acks(1, 40);
        req_i = '0;

        // zero-wait write, master 1
        set_m(1, 1'b1, 4'hF, 32'h100, 32'h1234_5678);
        push(1, 32'h100, 1'b1, 4'hF, 32'h1234_5678, 0, 0,
             32'hCAFE_0001, 1'b0, BW + 1);
        req_i = 2'b10;
        wait_acks(2, 40);
        req_i = '0;

        // continuous contention: strict alternation
        set_m(0, 1'b0, 4'h0, 32'hA000, 32'h0);
        set_m(1, 1'b1, 4'h3, 32'hB000, 32'h55);
        for (int k = 0; k < 3; k++) begin
            push(0, 32'hA000, 1'b0, 4'h0, 32'h0, 1, 3,
                 32'h100 + k, 1'b0, 5);
            push(1, 32'hB000, 1'b1, 4'h3, 32'h55, 0, 0,
                 32'h200 + k, 1'b0, BW + 1);
        end
        req_i = 2'b11;
        wait_acks(8, 200);
        req_i = '0;

        // back-to-back same address, master 0
        base = issue_cnt;
        set_m(0, 1'b0, 4'h0, 32'h9000, 32'h0);
        push(0, 32'h9000, 1'b0, 4'h0, 32'h0, 2, 3, 32'h11, 1'b0, 6);
        push(0, 32'h9000, 1'b0, 4'h0, 32'h0, 2, 3, 32'h22, 1'b0, 6);
        req_i = 2'b01;
        wait_acks(10, 60);
        req_i = '0;
        check("b2b_issues", 64'(issue_cnt - base), 64'(2));

        // reset during WAIT aborts master 1, then master 0 wins first
        set_m(1, 1'b0, 4'h0, 32'hC000, 32'h0);
        push(1, 32'hC000, 1'b0, 4'h0, 32'h0, 2, 20, 32'h99, 1'b0, 23);
        base = issue_cnt;
        req_i = 2'b10;
        n = 0;
        while (issue_cnt == base && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("abort_issue", 64'(issue_cnt), 64'(base + 1));
        repeat (4) @(posedge clk);
        #1;
        base = ack_cnt;
        reset_n = 1'b0;
        #1;
        check_idle("mid_rst");
        req_i = '0;
        wait_slave_idle(40);
        void'(txn_q.pop_front());
        @(negedge clk);
        check("rst_noack", 64'(ack_cnt), 64'(base));
        reset_n = 1'b1;
        set_m(0, 1'b0, 4'h0, 32'hA000, 32'h0);
        set_m(1, 1'b1, 4'h1, 32'hB000, 32'h77);
        push(0, 32'hA000, 1'b0, 4'h0, 32'h0, 1, 2, 32'h33, 1'b0, 4);
        push(1, 32'hB000, 1'b1, 4'h1, 32'h77, 0, 0, 32'h44, 1'b0, BW + 1);
        req_i = 2'b11;
        wait_acks(base + 2, 60);
        req_i = '0;

`ifdef BUS_ARB_TIMEOUT_EN
        set_m(0, 1'b0, 4'h0, 32'hD000, 32'h0);
        push(0, 32'hD000, 1'b0, 4'h0, 32'h0, 2, 30, 32'h0, 1'b1, TO + 1);
        req_i = 2'b01;
        wait_acks(base + 3, 60);
        req_i = '0;
        wait_slave_idle(60);
`endif

        repeat (4) @(negedge clk);
        check("q_empty", 64'(txn_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
